// File: rtl/mp_burst_arbiter_pkg.sv
// mp_pkg: shared state, beat-counter and per-core request types for the burst arbiter
package mp_pkg;
    localparam int MP_NCORES = 4;
    localparam int MP_AW = 11;
    localparam int MP_DW = 8;
    localparam int MP_BLW = 3;
    typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} mp_arb_state_e;
    typedef logic [MP_BLW-1:0] beat_t;
    typedef struct packed {
        logic we;
        logic [MP_AW-1:0] addr;
        logic [MP_BLW-1:0] blen;
    } core_req_t;
endpackage

// File: rtl/mp_burst_arbiter_if.sv
// mp_burst_arbiter_if: flattened core request buses plus the tagged read-response channel
interface mp_burst_arbiter_if #(
    parameter int NCORES = 4,
    parameter int AW = 11,
    parameter int DW = 8,
    parameter int BLW = 3,
    parameter int CIDW = $clog2(NCORES)
);
    logic [NCORES-1:0] req;
    logic [NCORES-1:0] we;
    logic [NCORES*AW-1:0] addr;
    logic [NCORES*DW-1:0] wdata;
    logic [NCORES*BLW-1:0] blen;
    logic [NCORES-1:0] gnt;
    logic busy;
    logic rvalid;
    logic [CIDW-1:0] rid;
    logic [DW-1:0] rdata;
    logic rlast;
    modport master (
        output req, we, addr, wdata, blen,
        input gnt, busy, rvalid, rid, rdata, rlast
    );
    modport slave (
        input req, we, addr, wdata, blen,
        output gnt, busy, rvalid, rid, rdata, rlast
    );
endinterface

// File: rtl/mp_rr_picker.sv
// mp_rr_picker: one-hot round-robin select, search starts just after the last granted core
module mp_rr_picker #(
    parameter int NCORES = 4,
    parameter int CIDW = $clog2(NCORES)
) (
    input  logic [NCORES-1:0] req,
    input  logic [CIDW-1:0]   last,
    output logic [NCORES-1:0] gnt,
    output logic [CIDW-1:0]   id
);
    logic [CIDW-1:0] idx;
    logic found;
    // walk the cores in rotated order and keep the first requester found
    always_comb begin
        gnt = '0;
        id = '0;
        found = 1'b0;
        idx = '0;
        for (int k = 1; k <= NCORES; k++) begin
            idx = CIDW'((int'(last) + k) % NCORES);
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt[idx] = 1'b1;
                id = idx;
            end
        end
    end
endmodule

// File: rtl/mp_burst_arbiter.sv
// mp_burst_arbiter: N-core round-robin burst front end owning the shared data memory
module mp_burst_arbiter
    import mp_pkg::*;
#(
    parameter int NCORES = MP_NCORES,
    parameter int AW = MP_AW,
    parameter int DW = MP_DW,
    parameter int BLW = MP_BLW,
    parameter int CIDW = $clog2(NCORES)
) (
    input logic clk,
    input logic rst,
    mp_burst_arbiter_if.slave bus
);
    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_BURST = BURST;
    logic [0:0] state;
    logic [CIDW-1:0] id;
    logic [CIDW-1:0] last_granted;
    logic [CIDW-1:0] pick_id;
    logic [NCORES-1:0] pick;
    core_req_t cr [NCORES];
    core_req_t cur;
    beat_t beat;
    logic busy;
    logic burst_end;
    logic rd_beat;
    logic [AW-1:0] baddr;
    logic [DW-1:0] mem [2**AW];
    for (genvar i = 0; i < NCORES; i++) begin : g_unpack
        assign cr[i] = '{we: bus.we[i], addr: bus.addr[i*AW +: AW], blen: bus.blen[i*BLW +: BLW]};
    end
    mp_rr_picker #(.NCORES(NCORES), .CIDW(CIDW)) u_pick (
        .req(bus.req),
        .last(last_granted),
        .gnt(pick),
        .id(pick_id)
    );
    assign busy = state == S_BURST;
    assign burst_end = beat == cur.blen;
    assign rd_beat = busy && !cur.we;
    assign baddr = cur.addr + AW'(beat);
    assign bus.busy = busy;
    assign bus.gnt = busy ? {{(NCORES-1){1'b0}}, 1'b1} << id : '0;
    // arbitrate in IDLE, then run one beat per cycle until the latched length is reached
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            last_granted <= CIDW'(NCORES - 1);
            id <= '0;
            cur <= '0;
            beat <= '0;
        end else if (state == S_IDLE) begin
            if (|pick) begin
                state <= S_BURST;
                id <= pick_id;
                cur <= cr[pick_id];
                beat <= '0;
            end
        end else begin
            beat <= beat + beat_t'(1);
            if (burst_end) begin
                state <= S_IDLE;
                last_granted <= id;
            end
        end
    end
    // write beats commit at the edge closing their grant cycle; reset blocks the commit
    always_ff @(posedge clk) begin
        if (!rst && busy && cur.we) mem[baddr] <= bus.wdata[id*DW +: DW];
    end
    // registered read response, tagged with the owning core and flagged on the final beat
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rvalid <= 1'b0;
            bus.rid <= '0;
            bus.rdata <= '0;
            bus.rlast <= 1'b0;
        end else begin
            bus.rvalid <= rd_beat;
            bus.rlast <= rd_beat && burst_end;
            if (rd_beat) begin
                bus.rid <= id;
                bus.rdata <= mem[baddr];
            end
        end
    end
endmodule

// File: tb/tb_mp_burst_arbiter.sv
// tb_mp_burst_arbiter: directed bursts with hand-computed grants, read data and timing
module tb_mp_burst_arbiter;
    localparam int NC = 4;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int BLW = 3;
    logic clk = 1'b0;
    logic rst;
    int n_vec = 0;
    int n_err = 0;
    int waited;
    logic [7:0] dv [8];
    int pat [10] = '{0, 1, 0, 2, 0, 4, 0, 8, 0, 1};
    always #5 clk = ~clk;
    mp_burst_arbiter_if #(.NCORES(NC), .AW(AW), .DW(DW), .BLW(BLW)) bus ();
    mp_burst_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .BLW(BLW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic set_core(input int c, input logic w, input logic [10:0] a, input int bl);
        bus.we[c] = w;
        bus.addr[c*AW +: AW] = a;
        bus.blen[c*BLW +: BLW] = 3'(bl);
    endtask
    task automatic wait_gnt();
        waited = 0;
        @(negedge clk);
        while (bus.gnt == '0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("gnt_timeout", waited < 20, 1);
    endtask
    task automatic check_resp(input logic v, input int c, input logic [7:0] d, input logic l);
        check("rvalid", bus.rvalid, v);
        check("rlast", bus.rlast, l);
        if (v) begin
            check("rid", bus.rid, c);
            check("rdata", bus.rdata, d);
        end
    endtask
    task automatic run_burst(input int c, input logic w, input logic [10:0] a, input int bl);
        set_core(c, w, a, bl);
        bus.wdata[c*DW +: DW] = dv[0];
        bus.req[c] = 1'b1;
        wait_gnt();
        bus.req[c] = 1'b0;
        for (int k = 0; k <= bl; k++) begin
            check("burst_gnt", bus.gnt, 32'(1) << c);
            check("burst_busy", bus.busy, 1);
            if (w) bus.wdata[c*DW +: DW] = dv[k];
            if (k > 0) check_resp(!w, c, dv[k-1], 1'b0);
            @(negedge clk);
        end
        check("end_gnt", bus.gnt, 0);
        check_resp(!w, c, dv[bl], !w);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.we = '0;
        bus.addr = '0;
        bus.wdata = '0;
        bus.blen = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", bus.gnt, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rid", bus.rid, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_rlast", bus.rlast, 0);
        rst = 1'b0;
        dv[0] = 8'hA5;
        run_burst(0, 1'b1, 11'h010, 0);
        check("lat_wr", waited, 0);
        run_burst(0, 1'b0, 11'h010, 0);
        check("lat_rd", waited, 0);
        dv[0] = 8'h11;
        dv[1] = 8'h22;
        dv[2] = 8'h33;
        dv[3] = 8'h44;
        run_burst(2, 1'b1, 11'h7FE, 3);
        run_burst(2, 1'b0, 11'h7FE, 3);
        dv[0] = 8'h33;
        run_burst(1, 1'b0, 11'h000, 0);
        rst = 1'b1;
        bus.req = '1;
        for (int c = 0; c < NC; c++) set_core(c, 1'b1, 11'(11'h100 + c), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("rr_order", bus.gnt, pat[k]);
        end
        bus.req = '0;
        set_core(1, 1'b1, 11'h200, 7);
        bus.wdata[DW +: DW] = 8'h30;
        bus.req[1] = 1'b1;
        wait_gnt();
        for (int k = 0; k < 8; k++) begin
            check("long_gnt", bus.gnt, 2);
            bus.wdata[DW +: DW] = 8'(8'h30 + k);
            if (k == 3) begin
                bus.req[1] = 1'b0;
                set_core(1, 1'b0, 11'h555, 1);
                set_core(0, 1'b0, 11'h010, 0);
                bus.req[0] = 1'b1;
            end
            @(negedge clk);
        end
        check("bubble", bus.gnt, 0);
        @(negedge clk);
        check("next_core0", bus.gnt, 1);
        bus.req[0] = 1'b0;
        @(negedge clk);
        check_resp(1'b1, 0, 8'hA5, 1'b1);
        for (int k = 0; k < 8; k++) dv[k] = 8'(8'h30 + k);
        run_burst(1, 1'b0, 11'h200, 7);
        set_core(3, 1'b0, 11'h200, 5);
        bus.req[3] = 1'b1;
        wait_gnt();
        check("c3_beat0", bus.gnt, 8);
        bus.req[3] = 1'b0;
        @(negedge clk);
        check("c3_beat1", bus.gnt, 8);
        check_resp(1'b1, 3, 8'h30, 1'b0);
        @(negedge clk);
        check("c3_beat2", bus.gnt, 8);
        rst = 1'b1;
        bus.req = '1;
        for (int c = 0; c < NC; c++) set_core(c, 1'b0, 11'h010, 0);
        @(negedge clk);
        check("abort_gnt", bus.gnt, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_rvalid", bus.rvalid, 0);
        check("abort_rlast", bus.rlast, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_first", bus.gnt, 1);
        bus.req = '0;
        @(negedge clk);
        check_resp(1'b1, 0, 8'hA5, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
